// File: rtl/rvfi_complete_pkg.sv
// Shared types and constants for the RVFI completeness monitor.
package rvfi_complete_pkg;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_UNSPEC_IMPL = 2'd1,
    ERR_SPEC_UNIMPL = 2'd2,
    ERR_ORDER       = 2'd3
  } err_kind_e;

  typedef enum logic [1:0] {
    ST_SKIP  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/rvfi_complete_classify.sv
// Per-channel classification of RTL trap status against the ISA spec model.
module rvfi_complete_classify
  import rvfi_complete_pkg::*;
(
  input  logic       valid,
  input  logic       trap,
  input  logic [6:0] insn,
  input  logic       spec_valid,
  input  logic       spec_trap,
  output logic       checked,
  output logic       fail,
  output err_kind_e  kind
);

  logic spec_ok;
  logic is_system;

  assign spec_ok   = spec_valid && !spec_trap;
  assign is_system = (insn == OPC_SYSTEM);

  // SYSTEM retirements still count as checked, they just never classify
  always_comb begin
    checked = valid;
    fail    = 1'b0;
    kind    = ERR_NONE;
    if (valid && !is_system) begin
      if (!trap && !spec_ok) begin
        fail = 1'b1;
        kind = ERR_UNSPEC_IMPL;
      end else if (trap && spec_ok) begin
        fail = 1'b1;
        kind = ERR_SPEC_UNIMPL;
      end
    end
  end

endmodule

// File: rtl/rvfi_complete_monitor.sv
// Multi-retire RVFI completeness monitor: FSM, skip window, first-failure capture, stats.
// Optional retire-order tracking is enabled by defining RVFI_COMPLETE_ORDER_CHECK_EN.
module rvfi_complete_monitor
  import rvfi_complete_pkg::*;
#(
  parameter int NRET        = 2,
  parameter int ILEN        = 32,
  parameter int SKIP_CYCLES = 0,
  parameter int CNT_W       = 32,
  localparam int CHAN_W     = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET*ILEN-1:0] rvfi_insn,
  input  logic [NRET*64-1:0]   rvfi_order,
  input  logic [NRET-1:0]      spec_valid,
  input  logic [NRET-1:0]      spec_trap,
  output logic                 err,
  output logic [1:0]           err_kind,
  output logic [CHAN_W-1:0]    err_chan,
  output logic [63:0]          err_order,
  output logic [ILEN-1:0]      err_insn,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     trap_cnt
);

  localparam int SKIP_W = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES + 1) : 1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  state_e          state;
  logic [SKIP_W-1:0] skip_cnt;
  logic [NRET-1:0] chk;
  logic [NRET-1:0] cls_fail;
  logic [NRET-1:0] ord_fail;
  err_kind_e       cls_kind [NRET];
  logic            active;

  for (genvar g = 0; g < NRET; g++) begin : g_cls
    rvfi_complete_classify u_cls (
      .valid      (rvfi_valid[g]),
      .trap       (rvfi_trap[g]),
      .insn       (rvfi_insn[g*ILEN +: 7]),
      .spec_valid (spec_valid[g]),
      .spec_trap  (spec_trap[g]),
      .checked    (chk[g]),
      .fail       (cls_fail[g]),
      .kind       (cls_kind[g])
    );
  end

  assign active = (state != ST_SKIP);

  logic [CNT_W-1:0] pop_chk;
  logic [CNT_W-1:0] pop_trap;

  always_comb begin
    pop_chk  = '0;
    pop_trap = '0;
    for (int k = 0; k < NRET; k++) begin
      if (chk[k])                pop_chk  = pop_chk + CNT_W'(1);
      if (chk[k] && rvfi_trap[k]) pop_trap = pop_trap + CNT_W'(1);
    end
  end

`ifdef RVFI_COMPLETE_ORDER_CHECK_EN
  logic [63:0] exp_order;

  // a channel after any invalid lower channel is a gap and fails order
  always_comb begin
    logic gap;
    gap      = 1'b0;
    ord_fail = '0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid[k]) begin
        if (state == ST_CHECK &&
            (gap || rvfi_order[k*64 +: 64] != exp_order + 64'(k)))
          ord_fail[k] = 1'b1;
      end else begin
        gap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_order <= '0;
    end else if (state == ST_SEED && |rvfi_valid) begin
      exp_order <= rvfi_order[63:0] + 64'(pop_chk);
    end else if (state == ST_CHECK) begin
      exp_order <= exp_order + 64'(pop_chk);
    end
  end
`else
  assign ord_fail = '0;
`endif

  logic              cap_hit;
  err_kind_e         cap_kind;
  logic [CHAN_W-1:0] cap_chan;
  logic [63:0]       cap_order;
  logic [ILEN-1:0]   cap_insn;

  // descending scan so the lowest failing channel is the one left standing
  always_comb begin
    cap_hit   = 1'b0;
    cap_kind  = ERR_NONE;
    cap_chan  = '0;
    cap_order = '0;
    cap_insn  = '0;
    for (int k = NRET - 1; k >= 0; k--) begin
      if (cls_fail[k] || ord_fail[k]) begin
        cap_hit   = 1'b1;
        cap_kind  = cls_fail[k] ? cls_kind[k] : ERR_ORDER;
        cap_chan  = CHAN_W'(k);
        cap_order = rvfi_order[k*64 +: 64];
        cap_insn  = rvfi_insn[k*ILEN +: ILEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SKIP;
      skip_cnt   <= SKIP_W'(SKIP_CYCLES);
      err        <= 1'b0;
      err_kind   <= ERR_NONE;
      err_chan   <= '0;
      err_order  <= '0;
      err_insn   <= '0;
      retire_cnt <= '0;
      trap_cnt   <= '0;
    end else begin
      if (active) begin
        retire_cnt <= sat_add(retire_cnt, pop_chk);
        trap_cnt   <= sat_add(trap_cnt, pop_trap);
      end
      case (state)
        ST_SKIP: begin
          if (skip_cnt == '0) state <= ST_SEED;
          else                skip_cnt <= skip_cnt - SKIP_W'(1);
        end
        ST_SEED, ST_CHECK: begin
          if (cap_hit) begin
            state     <= ST_FAIL;
            err       <= 1'b1;
            err_kind  <= cap_kind;
            err_chan  <= cap_chan;
            err_order <= cap_order;
            err_insn  <= cap_insn;
          end else if (state == ST_SEED && |rvfi_valid) begin
            state <= ST_CHECK;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
